mitchell_mult_pipe: RTL

MITCHELL_MULT_PIPE -- requirements
Module: mitchell_mult_pipe

---
 rtl/mitchell_pkg.sv | 23 ++
 rtl/mitchell_log.sv | 43 ++++
 rtl/mitchell_mult_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/mitchell_pkg.sv
// Shared constants and elaboration-time helpers for the Mitchell log-domain multiplier.
package mitchell_pkg;

  localparam int CORR_SHIFT = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bias-correction offset added to the log sum; vanishes when the fraction is too narrow.
  function automatic int corr_offset(input int f);
    int r;
    r = 0;
    if (f >= CORR_SHIFT) r = 1 << (f - CORR_SHIFT);
    return r;
  endfunction

endpackage

// File: rtl/mitchell_log.sv
// Signed operand to Mitchell log form: saturated magnitude, leading-one position
// and left-aligned fraction below the leading one.
module mitchell_log
  import mitchell_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0]               v,
  output logic                           zero,
  output logic [clog2(WIDTH-1)-1:0]      k,
  output logic [WIDTH-3:0]               f
);

  localparam int M  = WIDTH - 1;
  localparam int F  = M - 1;
  localparam int KW = clog2(M);

  logic [WIDTH-1:0] neg;
  logic [M-1:0]     mag;
  logic [M-1:0]     norm;
  logic [KW-1:0]    sh;

  assign neg = -v;

  // The most negative input has no positive twin; clamp it to the largest magnitude.
  always_comb begin
    mag = v[M-1:0];
    if (v[WIDTH-1]) mag = neg[WIDTH-1] ? '1 : neg[M-1:0];
  end

  always_comb begin
    k = '0;
    for (int i = 0; i < M; i++) begin
      if (mag[i]) k = KW'(i);
    end
  end

  assign zero = (mag == '0);
  assign sh   = KW'(M - 1) - k;
  assign norm = mag << sh;
  assign f    = F'(norm);

endmodule

// File: rtl/mitchell_mult_pipe.sv
// Three-stage Mitchell approximate signed multiplier (log, add, antilog) with a
// single global advance signal for backpressure.
module mitchell_mult_pipe
  import mitchell_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 corr_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-2:0]   p
);

  localparam int M  = WIDTH - 1;
  localparam int F  = M - 1;
  localparam int KW = clog2(M);
  localparam int LW = KW + 1 + F;
  localparam int PW = 2 * WIDTH - 1;
  localparam logic [LW-1:0] CORR_OFS = LW'(corr_offset(F));

  logic adv;

  logic          za_next, zb_next;
  logic [KW-1:0] ka_next, kb_next;
  logic [F-1:0]  fa_next, fb_next;

  logic          v1_reg, za_reg, zb_reg, sign1_reg, corr1_reg;
  logic [KW-1:0] ka_reg, kb_reg;
  logic [F-1:0]  fa_reg, fb_reg;

  logic          v2_reg, sign2_reg, zero2_reg;
  logic [LW-1:0] l_next, l2_reg;

  logic [KW:0]      lk;
  logic [F-1:0]     lf;
  logic [F+2*M:0]   wide;
  logic [2*M-1:0]   mag;
  logic [PW-1:0]    p_next;

  logic          out_valid_reg;
  logic [PW-1:0] p_reg;

  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign p         = p_reg;

  mitchell_log #(.WIDTH(WIDTH)) u_log_a (.v(x), .zero(za_next), .k(ka_next), .f(fa_next));
  mitchell_log #(.WIDTH(WIDTH)) u_log_b (.v(y), .zero(zb_next), .k(kb_next), .f(fb_next));

  // Fraction carry ripples into the characteristic through the plain concatenated add.
  assign l_next = {1'b0, ka_reg, fa_reg} + {1'b0, kb_reg, fb_reg}
                + (corr1_reg ? CORR_OFS : '0);

  assign lk   = l2_reg[LW-1:F];
  assign lf   = l2_reg[F-1:0];
  assign wide = {{(2*M){1'b0}}, 1'b1, lf} << lk;
  assign mag  = (2*M)'(wide >> F);

  always_comb begin
    p_next = {1'b0, mag};
    if (sign2_reg) p_next = -{1'b0, mag};
    if (zero2_reg) p_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      p_reg         <= '0;
    end else if (adv) begin
      v1_reg        <= in_valid;
      v2_reg        <= v1_reg;
      out_valid_reg <= v2_reg;
      if (v2_reg) p_reg <= p_next;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      ka_reg    <= ka_next;
      fa_reg    <= fa_next;
      za_reg    <= za_next;
      kb_reg    <= kb_next;
      fb_reg    <= fb_next;
      zb_reg    <= zb_next;
      sign1_reg <= x[WIDTH-1] ^ y[WIDTH-1];
      corr1_reg <= corr_en;
    end
    if (adv && v1_reg) begin
      l2_reg    <= l_next;
      sign2_reg <= sign1_reg;
      zero2_reg <= za_reg | zb_reg;
    end
  end

endmodule
